// File: rtl/note_player_pkg.sv
// note_player_pkg: shared constants, state encoding, bus payload type and
// half-period helpers for the note player.
package note_player_pkg;

    localparam int unsigned NOTE_W = 3;
    localparam int unsigned LED_W  = 7;
    localparam int unsigned HP_W   = 17;

    localparam logic [NOTE_W-1:0] NOTE_SIL = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_C   = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_D   = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_E   = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_F   = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_G   = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_A   = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_B   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // One sample of the note bus as seen by the synchroniser chain.
    typedef struct packed {
        logic [NOTE_W-1:0] code;
        logic              enable;
    } bus_t;

    // Half periods (in 50 MHz cycles) of the C..B tones.
    function automatic logic [HP_W-1:0] hp_table(input logic [NOTE_W-1:0] code);
        logic [HP_W-1:0] hp;
        case (code)
            NOTE_C:  hp = HP_W'(95556);
            NOTE_D:  hp = HP_W'(85131);
            NOTE_E:  hp = HP_W'(75843);
            NOTE_F:  hp = HP_W'(71586);
            NOTE_G:  hp = HP_W'(63776);
            NOTE_A:  hp = HP_W'(56818);
            NOTE_B:  hp = HP_W'(50619);
            default: hp = '0;
        endcase
        return hp;
    endfunction

    // Scaled half period, never below one cycle.
    function automatic logic [HP_W-1:0] half_period(input logic [NOTE_W-1:0] code,
                                                    input int unsigned       shift);
        logic [HP_W-1:0] hp;
        hp = hp_table(code) >> shift;
        if (hp == '0) begin
            hp = HP_W'(1);
        end
        return hp;
    endfunction

    // One-hot LED pattern for a note code; silence lights nothing.
    function automatic logic [LED_W-1:0] note_leds(input logic [NOTE_W-1:0] code);
        logic [LED_W-1:0] l;
        if (code == NOTE_SIL) begin
            l = '0;
        end else begin
            l = LED_W'(1) << (code - NOTE_W'(1));
        end
        return l;
    endfunction

endpackage

// File: rtl/note_player_if.sv
// note_player_if: the 3-bit note bus plus its enable strobe.
//   master: drives note_code / enable (game datapath)
//   slave : receives them (note_player)
interface note_player_if;
    import note_player_pkg::*;

    logic [NOTE_W-1:0] note_code;
    logic              enable;

    modport master (output note_code, output enable);
    modport slave  (input  note_code, input  enable);
endinterface

// File: rtl/note_player_tone_divider.sv
// tone_divider: square-wave generator. While run is high the buzzer toggles
// every half_period cycles; while run is low the counter and buzzer are held at 0.
//   clock, reset  : system clock, async active-low reset
//   run           : enable counting (low clears)
//   half_period   : toggle interval in cycles (>= 1)
//   buzzer        : registered tone output
module tone_divider
    import note_player_pkg::HP_W;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [HP_W-1:0] half_period,
    output logic            buzzer
);

    logic [HP_W-1:0] cnt_q;

    // Half-period counter and toggle flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            buzzer <= 1'b0;
        end else if (!run) begin
            cnt_q  <= '0;
            buzzer <= 1'b0;
        end else if (cnt_q == half_period - HP_W'(1)) begin
            cnt_q  <= '0;
            buzzer <= ~buzzer;
        end else begin
            cnt_q  <= cnt_q + HP_W'(1);
        end
    end

endmodule

// File: rtl/note_player.sv
// note_player: synchronises and glitch-filters the note bus, accepts one note
// per bus edge, plays it as a square wave for DUR_M cycles, then stays silent
// for GAP_M cycles.
//   clock, reset : system clock, async active-low reset
//   bus          : note_code / enable (slave modport)
//   buzzer       : square-wave tone
//   busy         : high while playing or in the gap
//   note_done    : one-cycle pulse when a note's duration completes
//   cur_note     : latched code of the note in progress, 0 when idle
//   leds         : one-hot of cur_note, 0 when idle
module note_player
    import note_player_pkg::*;
#(
    parameter int unsigned DUR_M       = 25_000_000,
    parameter int unsigned GAP_M       = 2_500_000,
    parameter int unsigned W_CNT       = 25,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic              clock,
    input  logic              reset,
    note_player_if.slave      bus,
    output logic              buzzer,
    output logic              busy,
    output logic              note_done,
    output logic [NOTE_W-1:0] cur_note,
    output logic [LED_W-1:0]  leds
);

    localparam logic [W_CNT-1:0] DUR_LAST = W_CNT'(DUR_M - 1);
    localparam logic [W_CNT-1:0] GAP_LAST = W_CNT'(GAP_M - 1);

    bus_t              s1_q, s2_q, s3_q;
    state_t            state_q, state_d;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [NOTE_W-1:0] cur_note_d;
    logic              note_done_d;
    logic              stable_c, rearm_c, accept_c, run_c;
    logic [HP_W-1:0]   hp_c;

    // Two-flop synchroniser plus a third stage used for the stability check.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {bus.note_code, bus.enable};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // A sample only counts once it has held for two consecutive cycles.
    assign stable_c = (s2_q == s3_q);
    assign rearm_c  = stable_c && (!s2_q.enable || s2_q.code == NOTE_SIL);
    assign accept_c = (state_q == IDLE) && stable_c && s2_q.enable &&
                      (s2_q.code != NOTE_SIL) && armed_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        cur_note_d  = cur_note;
        note_done_d = 1'b0;

        if (rearm_c) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept_c) begin
                    state_d    = PLAY;
                    cur_note_d = s2_q.code;
                    armed_d    = 1'b0;
                end
            end
            PLAY: begin
                if (cnt_q == DUR_LAST) begin
                    state_d     = GAP;
                    cnt_d       = '0;
                    note_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    cur_note_d = NOTE_SIL;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                cur_note_d = NOTE_SIL;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            cur_note  <= NOTE_SIL;
            leds      <= '0;
            busy      <= 1'b0;
            note_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            cur_note  <= cur_note_d;
            leds      <= note_leds(cur_note_d);
            busy      <= (state_d != IDLE);
            note_done <= note_done_d;
        end
    end

    // Tone runs only on PLAY cycles that stay in PLAY, so the first toggle
    // lands HP cycles after entry and the buzzer is forced low on exit.
    assign run_c = (state_q == PLAY) && (state_d == PLAY);
    assign hp_c  = half_period(cur_note, SCALE_SHIFT);

    tone_divider u_tone (
        .clock       (clock),
        .reset       (reset),
        .run         (run_c),
        .half_period (hp_c),
        .buzzer      (buzzer)
    );

endmodule
